// File: rtl/apb_master_mp.sv
// rtl/apb_master_mp.sv - APB master bridging a valid/ready request port onto NUM_SLAVES one-hot selects
// Address bits [SLV_SHIFT +: SW] pick the slave; decode errors and wait-state timeouts answer with RSP_ERR.

module apb_master_mp #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_SHIFT      = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             REQ_VALID,
    output logic                             REQ_READY,
    input  logic                             REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0]            REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]            REQ_WDATA,
    input  logic [DATA_WIDTH/8-1:0]          REQ_STRB,
    input  logic [2:0]                       REQ_PROT,
    output logic                             RSP_VALID,
    output logic [DATA_WIDTH-1:0]            RSP_RDATA,
    output logic                             RSP_ERR,
    output logic                             RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [2:0]                       PPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic [1:0]                       STATE
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SB = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SB-1:0]         r_strb;
    logic [2:0]            r_prot;
    logic                  r_write;
    logic [SW-1:0]         r_idx;
    logic [CW-1:0]         r_wait_cnt;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [SW-1:0]         w_req_idx;
    logic                  w_idx_ok;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_decode_err;
    logic                  w_wait_inc;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic [NUM_SLAVES-1:0] w_onehot;

    assign w_req_idx = REQ_ADDR[SLV_SHIFT +: SW];
    assign w_idx_ok  = 32'(w_req_idx) < NUM_SLAVES;
    assign w_accept  = REQ_VALID && (r_state == S_IDLE);

    // Only the latched slave's handshake lines are looked at; everyone else is ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        w_onehot    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == SW'(i)) begin
                w_sel_ready = PREADY[i];
                w_sel_err   = PSLVERR[i];
                w_sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        w_decode_err = 1'b0;
        w_wait_inc   = 1'b0;
        REQ_READY    = 1'b0;
        PSEL         = '0;
        PENABLE      = 1'b0;
        case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    if (w_idx_ok) begin
                        w_next = S_SETUP;
                    end else begin
                        w_decode_err = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                PSEL   = w_onehot;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = w_onehot;
                PENABLE = 1'b1;
                // A ready slave wins over a timeout landing on the same cycle.
                if (w_sel_ready) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if ((TIMEOUT_CYCLES > 0) && (r_wait_cnt == TO_LAST)) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_strb        <= '0;
            r_prot        <= '0;
            r_write       <= 1'b0;
            r_idx         <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_rsp_valid   <= w_done | w_abort | w_decode_err;
            r_rsp_err     <= (w_done & w_sel_err) | w_abort | w_decode_err;
            r_rsp_timeout <= w_abort;
            r_rsp_rdata   <= (w_done && !r_write && !w_sel_err) ? w_sel_rdata : '0;
            if (w_accept) begin
                r_addr  <= REQ_ADDR;
                r_wdata <= REQ_WDATA;
                r_strb  <= REQ_STRB;
                r_prot  <= REQ_PROT;
                r_write <= REQ_WRITE;
                r_idx   <= w_req_idx;
            end
            if (r_state == S_SETUP) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc || w_abort) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    assign PADDR       = r_addr;
    assign PWDATA      = r_wdata;
    assign PSTRB       = r_strb;
    assign PPROT       = r_prot;
    assign PWRITE      = r_write;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_ERR     = r_rsp_err;
    assign RSP_TIMEOUT = r_rsp_timeout;
    assign RSP_RDATA   = r_rsp_rdata;
    assign STATE       = r_state;

endmodule
